// File: rtl/seq_ctrl_if.sv
// Handshake bundle between the sequencer and its environment: run/step control,
// RAM stall, instruction opcode in; sequencer state and status out.
interface seq_ctrl_if #(
    parameter int OPCODE_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
);
    logic                    run;
    logic                    step;
    logic                    ram_busy;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [2:0]              q;
    logic                    busy;
    logic                    halted;
    logic                    stall_err;
    logic [COUNT_WIDTH-1:0]  instr_count;

    modport master (
        output run, step, ram_busy, opcode,
        input  q, busy, halted, stall_err, instr_count
    );

    modport slave (
        input  run, step, ram_busy, opcode,
        output q, busy, halted, stall_err, instr_count
    );
endinterface

// File: rtl/seq_ctrl.sv
// Instruction sequencer feeding the CPU core: walks one instruction through
// SREAD..SNXT with run/step control, RAM stalls, halt opcode and stall watchdog.
module seq_ctrl #(
    parameter logic [7:0] HALT_OPCODE  = 8'hFF,
    parameter int         STALL_MAX    = 15,
    parameter int         COUNT_WIDTH  = 16,
    parameter int         OPCODE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    seq_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        SRST   = 3'd0,
        SREAD  = 3'd1,
        SLOAD1 = 3'd2,
        SLOAD2 = 3'd3,
        SLOAD3 = 3'd4,
        SCALC  = 3'd5,
        SWRITE = 3'd6,
        SNXT   = 3'd7
    } state_t;

    localparam int SCW = $clog2(STALL_MAX + 1);

    state_t                 state, state_nxt;
    logic [SCW-1:0]         stall_cnt, stall_cnt_nxt;
    logic                   halt_flag, halt_flag_nxt;
    logic                   halted, halted_nxt;
    logic                   stall_err, stall_err_nxt;
    logic [COUNT_WIDTH-1:0] instr_count, instr_count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SRST;
            stall_cnt   <= '0;
            halt_flag   <= 1'b0;
            halted      <= 1'b0;
            stall_err   <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            stall_cnt   <= stall_cnt_nxt;
            halt_flag   <= halt_flag_nxt;
            halted      <= halted_nxt;
            stall_err   <= stall_err_nxt;
            instr_count <= instr_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        stall_cnt_nxt   = '0;
        halt_flag_nxt   = halt_flag;
        halted_nxt      = halted;
        stall_err_nxt   = stall_err;
        instr_count_nxt = instr_count;
        case (state)
            SRST: begin
                if ((bus.run | bus.step) & ~halted & ~stall_err)
                    state_nxt = SREAD;
            end
            SREAD: state_nxt = SLOAD1;
            SLOAD1, SLOAD2, SLOAD3, SCALC, SWRITE: begin
                if (bus.ram_busy) begin
                    // The stall that reaches the limit aborts the instruction unretired.
                    if (stall_cnt == SCW'(STALL_MAX - 1)) begin
                        state_nxt     = SRST;
                        stall_err_nxt = 1'b1;
                        halt_flag_nxt = 1'b0;
                    end else begin
                        stall_cnt_nxt = stall_cnt + 1'b1;
                    end
                end else begin
                    case (state)
                        SLOAD1:  state_nxt = SLOAD2;
                        SLOAD2:  state_nxt = SLOAD3;
                        SLOAD3:  state_nxt = SCALC;
                        SCALC:   state_nxt = SWRITE;
                        default: state_nxt = SNXT;
                    endcase
                    if (state == SLOAD1 && bus.opcode == OPCODE_WIDTH'(HALT_OPCODE))
                        halt_flag_nxt = 1'b1;
                end
            end
            SNXT: begin
                if (instr_count != '1)
                    instr_count_nxt = instr_count + 1'b1;
                if (halt_flag) begin
                    state_nxt     = SRST;
                    halted_nxt    = 1'b1;
                    halt_flag_nxt = 1'b0;
                end else if (bus.run) begin
                    state_nxt = SREAD;
                end else begin
                    state_nxt = SRST;
                end
            end
            default: state_nxt = SRST;
        endcase
    end

    assign bus.q           = state;
    assign bus.busy        = (state != SRST);
    assign bus.halted      = halted;
    assign bus.stall_err   = stall_err;
    assign bus.instr_count = instr_count;
endmodule
